// File: rtl/lcd_bus_arbiter.sv
// Two-requester round-robin arbiter for an HD44780-style LCD bus, generating setup/EN/hold timing.
// Optional bus lock per requester is enabled by defining LCD_ARB_LOCK_EN.
module lcd_bus_arbiter #(
  parameter int unsigned T_SETUP = 2,
  parameter int unsigned T_PULSE = 25,
  parameter int unsigned T_CMD   = 50_000,
  parameter int unsigned T_LONG  = 100_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic       req0_rs,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
`ifdef LCD_ARB_LOCK_EN
  input  logic       req0_lock,
`endif
  input  logic       req1_valid,
  input  logic       req1_rs,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
`ifdef LCD_ARB_LOCK_EN
  input  logic       req1_lock,
`endif
  output logic       lcd_en,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] lcd_data,
  output logic       busy,
  output logic       grant_id
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_PULSE = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  localparam int unsigned T_MAX = (T_CMD > T_LONG) ? T_CMD : T_LONG;
  localparam int unsigned CW    = $clog2(T_MAX + 1);

  localparam logic [CW-1:0] SETUP_END = CW'(T_SETUP - 1);
  localparam logic [CW-1:0] PULSE_END = CW'(T_PULSE - 1);
  localparam logic [CW-1:0] CMD_END   = CW'(T_CMD - 1);
  localparam logic [CW-1:0] LONG_END  = CW'(T_LONG - 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          en_q, busy_q;
  logic          rs_q, gid_q, long_q, last_q;
  logic [7:0]    data_q;

  logic          elig0_s, elig1_s, win_s, accept_s, win_rs_s, long_cmd_s;
  logic [7:0]    win_data_s;
  logic [CW-1:0] hold_end_s;

`ifdef LCD_ARB_LOCK_EN
  logic lock_q;

  // While locked, only the owner of the last transfer may be granted.
  always_comb begin
    elig0_s = req0_valid & ~(lock_q & gid_q);
    elig1_s = req1_valid & ~(lock_q & ~gid_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q <= 1'b0;
    end else if (accept_s) begin
      lock_q <= win_s ? req1_lock : req0_lock;
    end else begin
      lock_q <= lock_q;
    end
  end
`else
  always_comb begin
    elig0_s = req0_valid;
    elig1_s = req1_valid;
  end
`endif

  // With both eligible, the requester not granted last wins.
  always_comb begin
    win_s      = (elig0_s & elig1_s) ? ~last_q : elig1_s;
    accept_s   = (state_q == S_IDLE) & (elig0_s | elig1_s);
    req0_ready = accept_s & ~win_s;
    req1_ready = accept_s & win_s;
    win_rs_s   = win_s ? req1_rs : req0_rs;
    win_data_s = win_s ? req1_data : req0_data;
    long_cmd_s = ~win_rs_s & ((win_data_s == 8'h01) | (win_data_s == 8'h02) |
                              (win_data_s == 8'h03));
    hold_end_s = long_q ? LONG_END : CMD_END;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (accept_s) state_d = S_SETUP;
        else          state_d = S_IDLE;
      end
      S_SETUP: begin
        if (cnt_q == SETUP_END) begin
          state_d = S_PULSE;
          cnt_d   = '0;
        end else begin
          state_d = S_SETUP;
        end
      end
      S_PULSE: begin
        if (cnt_q == PULSE_END) begin
          state_d = S_HOLD;
          cnt_d   = '0;
        end else begin
          state_d = S_PULSE;
        end
      end
      S_HOLD: begin
        if (cnt_q == hold_end_s) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          state_d = S_HOLD;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // EN and busy are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= (state_d == S_PULSE);
      busy_q  <= (state_d != S_IDLE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs_q   <= 1'b0;
      data_q <= 8'h00;
      gid_q  <= 1'b0;
      long_q <= 1'b0;
      last_q <= 1'b1;
    end else if (accept_s) begin
      rs_q   <= win_rs_s;
      data_q <= win_data_s;
      gid_q  <= win_s;
      long_q <= long_cmd_s;
      last_q <= win_s;
    end else begin
      rs_q   <= rs_q;
      data_q <= data_q;
      gid_q  <= gid_q;
      long_q <= long_q;
      last_q <= last_q;
    end
  end

  assign lcd_en   = en_q;
  assign lcd_rs   = rs_q;
  assign lcd_rw   = 1'b0;
  assign lcd_data = data_q;
  assign busy     = busy_q;
  assign grant_id = gid_q;

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Directed self-checking bench for lcd_bus_arbiter with T_SETUP=2, T_PULSE=3, T_CMD=8, T_LONG=20.
// Expected grant order in the lock scenario depends on LCD_ARB_LOCK_EN.
module tb_lcd_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid = 1'b0, req0_rs = 1'b0, req0_ready, req0_lock = 1'b0;
  logic       req1_valid = 1'b0, req1_rs = 1'b0, req1_ready, req1_lock = 1'b0;
  logic [7:0] req0_data = 8'h00, req1_data = 8'h00;
  logic       lcd_en, lcd_rs, lcd_rw, busy, grant_id;
  logic [7:0] lcd_data;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  lcd_bus_arbiter #(.T_SETUP(2), .T_PULSE(3), .T_CMD(8), .T_LONG(20)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_rs(req0_rs), .req0_data(req0_data), .req0_ready(req0_ready),
`ifdef LCD_ARB_LOCK_EN
    .req0_lock(req0_lock),
`endif
    .req1_valid(req1_valid), .req1_rs(req1_rs), .req1_data(req1_data), .req1_ready(req1_ready),
`ifdef LCD_ARB_LOCK_EN
    .req1_lock(req1_lock),
`endif
    .lcd_en(lcd_en), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_data(lcd_data),
    .busy(busy), .grant_id(grant_id)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    rst_n = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (!busy) done = 1'b1;
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_timeout busy got %b want 0", busy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    n_cmp++;
    if ({lcd_en, lcd_rs, lcd_rw, lcd_data, busy, grant_id, req0_ready, req1_ready} !== 14'h0) begin
      n_fail++;
      $display("FAIL reset en/rs/rw/data/busy/gid/rdy0/rdy1 got %b want 0",
               {lcd_en, lcd_rs, lcd_rw, lcd_data, busy, grant_id, req0_ready, req1_ready});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_char();
    logic [3:0] exp_v;
    req0_valid = 1'b1; req0_rs = 1'b1; req0_data = 8'h41;
    for (int c = 0; c <= 14; c++) begin
      @(negedge clk);
      exp_v = {(c == 0 || c == 14), 1'b0, (c >= 3 && c <= 5), (c >= 1 && c <= 13)};
      n_cmp++;
      if ({req0_ready, req1_ready, lcd_en, busy} !== exp_v) begin
        n_fail++;
        $display("FAIL single c=%0d rdy0/rdy1/en/busy got %b want %b", c,
                 {req0_ready, req1_ready, lcd_en, busy}, exp_v);
      end
      if (c >= 1) begin
        n_cmp++;
        if ({grant_id, lcd_rs, lcd_data} !== 10'b0_1_0100_0001) begin
          n_fail++;
          $display("FAIL single_bus c=%0d gid/rs/data got %b want 0101000001", c,
                   {grant_id, lcd_rs, lcd_data});
        end
      end
      @(posedge clk);
      #1;
    end
    req0_valid = 1'b0;
    wait_idle();
  endtask

  task automatic test_clear();
    logic [3:0] exp_v;
    req1_valid = 1'b1; req1_rs = 1'b0; req1_data = 8'h01;
    for (int c = 0; c <= 26; c++) begin
      @(negedge clk);
      exp_v = {1'b0, (c == 0 || c == 26), (c >= 3 && c <= 5), (c >= 1 && c <= 25)};
      n_cmp++;
      if ({req0_ready, req1_ready, lcd_en, busy} !== exp_v) begin
        n_fail++;
        $display("FAIL clear c=%0d rdy0/rdy1/en/busy got %b want %b", c,
                 {req0_ready, req1_ready, lcd_en, busy}, exp_v);
      end
      if (c >= 1) begin
        n_cmp++;
        if ({grant_id, lcd_rs, lcd_data} !== 10'b1_0_0000_0001) begin
          n_fail++;
          $display("FAIL clear_bus c=%0d gid/rs/data got %b want 1000000001", c,
                   {grant_id, lcd_rs, lcd_data});
        end
      end
      @(posedge clk);
      #1;
    end
    req1_valid = 1'b0;
    wait_idle();
  endtask

  task automatic test_long_decode();
    logic [3:0] exp_v;
    req0_valid = 1'b1; req0_rs = 1'b1; req0_data = 8'h02;
    for (int c = 0; c <= 14; c++) begin
      @(negedge clk);
      exp_v = {(c == 0 || c == 14), 1'b0, (c >= 3 && c <= 5), (c >= 1 && c <= 13)};
      n_cmp++;
      if ({req0_ready, req1_ready, lcd_en, busy} !== exp_v) begin
        n_fail++;
        $display("FAIL long_decode c=%0d rdy0/rdy1/en/busy got %b want %b", c,
                 {req0_ready, req1_ready, lcd_en, busy}, exp_v);
      end
      @(posedge clk);
      #1;
    end
    req0_valid = 1'b0;
    wait_idle();
  endtask

  task automatic test_fairness();
    logic       exp_id [4];
    logic [7:0] exp_data [4];
    int  n_g = 0;
    bit  pend = 1'b0;
    logic acc0, acc1;
    exp_id   = '{1'b0, 1'b1, 1'b0, 1'b1};
    exp_data = '{8'h30, 8'h50, 8'h31, 8'h51};
    apply_reset();
    req0_valid = 1'b1; req0_rs = 1'b1; req0_data = 8'h30;
    req1_valid = 1'b1; req1_rs = 1'b1; req1_data = 8'h50;
    for (int c = 0; c < 120 && (n_g < 4 || pend); c++) begin
      @(negedge clk);
      if (pend) begin
        pend = 1'b0;
        n_cmp++;
        if ({grant_id, lcd_rs, lcd_data} !== {exp_id[n_g-1], 1'b1, exp_data[n_g-1]}) begin
          n_fail++;
          $display("FAIL fair_bus grant=%0d gid/rs/data got %b want %b", n_g - 1,
                   {grant_id, lcd_rs, lcd_data}, {exp_id[n_g-1], 1'b1, exp_data[n_g-1]});
        end
      end
      acc0 = req0_ready;
      acc1 = req1_ready;
      if (acc0 | acc1) begin
        n_cmp++;
        if ({acc0, acc1} !== {~exp_id[n_g], exp_id[n_g]}) begin
          n_fail++;
          $display("FAIL fair_order grant=%0d rdy0/rdy1 got %b want %b", n_g,
                   {acc0, acc1}, {~exp_id[n_g], exp_id[n_g]});
        end
        n_g++;
        pend = 1'b1;
      end
      @(posedge clk);
      #1;
      if (acc0) req0_data++;
      if (acc1) req1_data++;
      if (n_g == 4) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
    end
    n_cmp++;
    if (n_g != 4) begin
      n_fail++;
      $display("FAIL fair_count grants got %0d want 4", n_g);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_idle();
  endtask

  task automatic test_lock();
    logic       exp_id [4];
    logic [7:0] exp_data [4];
    logic       lock_tbl [3];
    int  n_g = 0, idx0 = 0;
    bit  pend = 1'b0;
    logic acc0, acc1;
`ifdef LCD_ARB_LOCK_EN
    exp_id   = '{1'b0, 1'b0, 1'b0, 1'b1};
    exp_data = '{8'h61, 8'h62, 8'h63, 8'h71};
`else
    exp_id   = '{1'b0, 1'b1, 1'b0, 1'b1};
    exp_data = '{8'h61, 8'h71, 8'h62, 8'h72};
`endif
    lock_tbl = '{1'b1, 1'b1, 1'b0};
    apply_reset();
    req0_valid = 1'b1; req0_rs = 1'b1; req0_data = 8'h61; req0_lock = lock_tbl[0];
    req1_valid = 1'b1; req1_rs = 1'b1; req1_data = 8'h71; req1_lock = 1'b0;
    for (int c = 0; c < 120 && (n_g < 4 || pend); c++) begin
      @(negedge clk);
      if (pend) begin
        pend = 1'b0;
        n_cmp++;
        if ({grant_id, lcd_data} !== {exp_id[n_g-1], exp_data[n_g-1]}) begin
          n_fail++;
          $display("FAIL lock_bus grant=%0d gid/data got %b want %b", n_g - 1,
                   {grant_id, lcd_data}, {exp_id[n_g-1], exp_data[n_g-1]});
        end
      end
      acc0 = req0_ready;
      acc1 = req1_ready;
      if (acc0 | acc1) begin
        n_cmp++;
        if ({acc0, acc1} !== {~exp_id[n_g], exp_id[n_g]}) begin
          n_fail++;
          $display("FAIL lock_order grant=%0d rdy0/rdy1 got %b want %b", n_g,
                   {acc0, acc1}, {~exp_id[n_g], exp_id[n_g]});
        end
        n_g++;
        pend = 1'b1;
      end
      @(posedge clk);
      #1;
      if (acc0) begin
        idx0++;
        if (idx0 >= 3) begin
          req0_valid = 1'b0;
        end else begin
          req0_data = req0_data + 8'h01;
          req0_lock = lock_tbl[idx0];
        end
      end
      if (acc1) req1_data++;
      if (n_g == 4) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
    end
    n_cmp++;
    if (n_g != 4) begin
      n_fail++;
      $display("FAIL lock_count grants got %0d want 4", n_g);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_lock  = 1'b0;
    wait_idle();
  endtask

  task automatic test_reset_mid();
    logic [3:0] exp_v;
    req1_valid = 1'b1; req1_rs = 1'b1; req1_data = 8'h48;
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      if (c == 4) begin
        n_cmp++;
        if (lcd_en !== 1'b1) begin
          n_fail++;
          $display("FAIL midrst_pre en got %b want 1", lcd_en);
        end
      end
      @(posedge clk);
      #1;
      req1_valid = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({lcd_en, busy, grant_id, lcd_rs, lcd_data, req0_ready, req1_ready} !== 14'h0) begin
      n_fail++;
      $display("FAIL midrst en/busy/gid/rs/data/rdy0/rdy1 got %b want 0",
               {lcd_en, busy, grant_id, lcd_rs, lcd_data, req0_ready, req1_ready});
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    req1_valid = 1'b1; req1_rs = 1'b1; req1_data = 8'h48;
    for (int c = 0; c <= 14; c++) begin
      @(negedge clk);
      exp_v = {1'b0, (c == 0), (c >= 3 && c <= 5), (c >= 1 && c <= 13)};
      n_cmp++;
      if ({req0_ready, req1_ready, lcd_en, busy} !== exp_v) begin
        n_fail++;
        $display("FAIL midrst_seq c=%0d rdy0/rdy1/en/busy got %b want %b", c,
                 {req0_ready, req1_ready, lcd_en, busy}, exp_v);
      end
      if (c >= 1) begin
        n_cmp++;
        if ({grant_id, lcd_rs, lcd_data} !== 10'b1_1_0100_1000) begin
          n_fail++;
          $display("FAIL midrst_bus c=%0d gid/rs/data got %b want 1101001000", c,
                   {grant_id, lcd_rs, lcd_data});
        end
      end
      @(posedge clk);
      #1;
      req1_valid = 1'b0;
    end
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_single_char();
    test_clear();
    test_long_decode();
    test_fairness();
    test_lock();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
